shared_data_rx_mc_m: RTL and testbench

- Parametrised multi-channel decoder for the shared-data byte stream arriving from the transceiver.
- Frame format: K-start, segment address, payload, K-stop, 16-bit checksum.
- Validates the frame, stores it in a holding buffer, then replays it word by word to CH_COUNT independent write ports, each with its own valid/ready handshake.
- Sits between the xcvr RX byte path and the per-DDSC shared-memory slaves.
- Extensions: explicit byte qualifier, configurable word width and depth, overlapped receive/drain, inactivity timeout, length check, overrun detection.

---
 rtl/shared_data_rx_mc_m.sv | 272 +++++++++++++++++++++++++++
 tb/tb_shared_data_rx_mc_m.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_data_rx_mc_m.sv
// Shared-data RX decoder: validates K-framed segment frames and replays them to CH_COUNT write ports.
// Optional statistics counters are built when SHARED_DATA_RX_STATS_EN is defined.
module shared_data_rx_mc_m #(
  parameter int          DATA_BYTES  = 4,
  parameter int          MAX_WORDS   = 16,
  parameter int          CH_COUNT    = 4,
  parameter int          ADDR_W      = 16,
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [7:0]  K_START     = 8'h5C,
  parameter logic [7:0]  K_STOP      = 8'h3C
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [7:0]                       rx_data,
  input  logic                             rx_isk,
  input  logic                             rx_valid,
  output logic [CH_COUNT-1:0]              wr_valid,
  input  logic [CH_COUNT-1:0]              wr_ready,
  output logic [CH_COUNT*ADDR_W-1:0]       wr_addr,
  output logic [CH_COUNT*DATA_BYTES*8-1:0] wr_data,
  output logic                             busy,
  output logic                             frame_ok,
  output logic                             frame_err
`ifdef SHARED_DATA_RX_STATS_EN
  ,
  output logic [15:0]                      crc_err_cnt,
  output logic [15:0]                      len_err_cnt,
  output logic [15:0]                      ovr_cnt,
  output logic [15:0]                      tmo_err_cnt
`endif
);

  localparam int DW    = DATA_BYTES * 8;
  localparam int IDX_W = $clog2(MAX_WORDS);
  localparam int WC_W  = IDX_W + 1;
  localparam int BC_W  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W-1:0] SEG_STRIDE  = ADDR_W'(MAX_WORDS * DATA_BYTES);
  localparam logic [ADDR_W-1:0] BYTE_STRIDE = ADDR_W'(DATA_BYTES);

  typedef enum logic [2:0] {
    RX_IDLE, RX_ADDR, RX_DATA, RX_CHK0, RX_CHK1, RX_CHECK
  } rx_state_t;
  typedef enum logic {CH_IDLE, CH_WRITE} ch_state_t;

  rx_state_t        r_rx_state, w_rx_next;
  logic [15:0]      r_chk, r_rx_chk;
  logic [7:0]       r_seg, r_hold_seg;
  logic [WC_W-1:0]  r_word_cnt, r_count, r_hold_count;
  logic [BC_W-1:0]  r_byte_cnt;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [DW-1:0]    r_asm  [MAX_WORDS];
  logic [DW-1:0]    r_hold [MAX_WORDS];
  logic             r_frame_ok, r_frame_err;

  ch_state_t        r_ch_state [CH_COUNT];
  ch_state_t        w_ch_next  [CH_COUNT];
  logic [IDX_W-1:0] r_idx      [CH_COUNT];
  logic [IDX_W-1:0] w_idx_next [CH_COUNT];

  logic w_start, w_stop, w_active, w_tmo, w_good;
  logic w_clear, w_seg_ld, w_byte_wr, w_stop_ld, w_chk_hi, w_chk_lo;
  logic w_err_len, w_err_k, w_err_tmo, w_accept, w_ovr, w_crc;

  assign w_start  = rx_isk && (rx_data == K_START);
  assign w_stop   = rx_isk && (rx_data == K_STOP);
  assign w_active = (r_rx_state == RX_ADDR) || (r_rx_state == RX_DATA) ||
                    (r_rx_state == RX_CHK0) || (r_rx_state == RX_CHK1);
  assign w_tmo    = w_active && !rx_valid && (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign w_good   = (r_chk == r_rx_chk) && (r_count != '0) && (r_seg != 8'hFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rx_state <= RX_IDLE;
    else     r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    w_clear   = 1'b0;
    w_seg_ld  = 1'b0;
    w_byte_wr = 1'b0;
    w_stop_ld = 1'b0;
    w_chk_hi  = 1'b0;
    w_chk_lo  = 1'b0;
    w_err_len = 1'b0;
    w_err_k   = 1'b0;
    w_err_tmo = 1'b0;
    w_accept  = 1'b0;
    w_ovr     = 1'b0;
    w_crc     = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (rx_valid && w_start) begin
          w_clear   = 1'b1;
          w_rx_next = RX_ADDR;
        end
      end
      RX_CHECK: begin
        w_rx_next = RX_IDLE;
        w_accept  = w_good && !busy;
        w_ovr     = w_good && busy;
        w_crc     = !w_good;
      end
      default: begin
        if (rx_valid) begin
          if (w_start) begin
            w_clear   = 1'b1;
            w_rx_next = RX_ADDR;
          end else if (rx_isk) begin
            if (r_rx_state == RX_DATA && w_stop) begin
              w_stop_ld = 1'b1;
              w_rx_next = RX_CHK0;
            end else begin
              w_err_k   = 1'b1;
              w_rx_next = RX_IDLE;
            end
          end else if (r_rx_state == RX_ADDR) begin
            w_seg_ld  = 1'b1;
            w_rx_next = RX_DATA;
          end else if (r_rx_state == RX_DATA) begin
            if (r_word_cnt == WC_W'(MAX_WORDS)) begin
              w_err_len = 1'b1;
              w_rx_next = RX_IDLE;
            end else begin
              w_byte_wr = 1'b1;
            end
          end else if (r_rx_state == RX_CHK0) begin
            w_chk_hi  = 1'b1;
            w_rx_next = RX_CHK1;
          end else begin
            w_chk_lo  = 1'b1;
            w_rx_next = RX_CHECK;
          end
        end else if (w_tmo) begin
          w_err_tmo = 1'b1;
          w_rx_next = RX_IDLE;
        end
      end
    endcase
  end

  // Assembly datapath; the holding buffer only changes on an accepted frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chk        <= 16'hFFFF;
      r_rx_chk     <= '0;
      r_seg        <= '0;
      r_word_cnt   <= '0;
      r_byte_cnt   <= '0;
      r_count      <= '0;
      r_tmo_cnt    <= '0;
      r_hold_seg   <= '0;
      r_hold_count <= '0;
      r_frame_ok   <= 1'b0;
      r_frame_err  <= 1'b0;
      for (int w = 0; w < MAX_WORDS; w++) begin
        r_asm[w]  <= '0;
        r_hold[w] <= '0;
      end
    end else begin
      r_frame_ok  <= w_accept;
      r_frame_err <= w_err_len | w_err_k | w_err_tmo | w_ovr | w_crc;
      if (w_active && !rx_valid) r_tmo_cnt <= r_tmo_cnt + 1'b1;
      else                       r_tmo_cnt <= '0;
      if (w_clear) begin
        r_chk      <= 16'hFFFF;
        r_word_cnt <= '0;
        r_byte_cnt <= '0;
        for (int w = 0; w < MAX_WORDS; w++) r_asm[w] <= '0;
      end
      if (w_seg_ld) begin
        r_seg <= rx_data;
        r_chk <= r_chk - {8'h00, rx_data};
      end
      if (w_byte_wr) begin
        r_chk <= r_chk - {8'h00, rx_data};
        for (int b = 0; b < DATA_BYTES; b++)
          if (r_byte_cnt == BC_W'(b)) r_asm[r_word_cnt[IDX_W-1:0]][b*8 +: 8] <= rx_data;
        if (r_byte_cnt == BC_W'(DATA_BYTES - 1)) begin
          r_byte_cnt <= '0;
          r_word_cnt <= r_word_cnt + 1'b1;
        end else begin
          r_byte_cnt <= r_byte_cnt + 1'b1;
        end
      end
      if (w_stop_ld) r_count <= r_word_cnt + {{(WC_W-1){1'b0}}, (r_byte_cnt != '0)};
      if (w_chk_hi)  r_rx_chk[15:8] <= rx_data;
      if (w_chk_lo)  r_rx_chk[7:0]  <= rx_data;
      if (w_accept) begin
        r_hold_seg   <= r_seg;
        r_hold_count <= r_count;
        for (int w = 0; w < MAX_WORDS; w++) r_hold[w] <= r_asm[w];
      end
    end
  end

  assign frame_ok  = r_frame_ok;
  assign frame_err = r_frame_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH_COUNT; c++) begin
        r_ch_state[c] <= CH_IDLE;
        r_idx[c]      <= '0;
      end
    end else begin
      for (int c = 0; c < CH_COUNT; c++) begin
        r_ch_state[c] <= w_ch_next[c];
        r_idx[c]      <= w_idx_next[c];
      end
    end
  end

  // Handshake: a word moves when wr_valid && wr_ready at a rising edge; addr/data hold while stalled.
  always_comb begin
    for (int c = 0; c < CH_COUNT; c++) begin
      w_ch_next[c]  = r_ch_state[c];
      w_idx_next[c] = r_idx[c];
      case (r_ch_state[c])
        CH_IDLE: begin
          if (w_accept) begin
            w_ch_next[c]  = CH_WRITE;
            w_idx_next[c] = '0;
          end
        end
        default: begin
          if (wr_ready[c]) begin
            if ((WC_W'(r_idx[c]) + WC_W'(1)) == r_hold_count) w_ch_next[c] = CH_IDLE;
            else                                               w_idx_next[c] = r_idx[c] + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int c = 0; c < CH_COUNT; c++)
      if (r_ch_state[c] == CH_WRITE) busy = 1'b1;
  end

  for (genvar c = 0; c < CH_COUNT; c++) begin : g_ch
    assign wr_valid[c]                = (r_ch_state[c] == CH_WRITE);
    assign wr_addr[c*ADDR_W +: ADDR_W] = ADDR_W'(r_hold_seg) * SEG_STRIDE +
                                         ADDR_W'(r_idx[c]) * BYTE_STRIDE;
    assign wr_data[c*DW +: DW]         = r_hold[r_idx[c]];
  end

`ifdef SHARED_DATA_RX_STATS_EN
  logic [15:0] r_crc_cnt, r_len_cnt, r_ovr_cnt, r_tmo_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crc_cnt     <= '0;
      r_len_cnt     <= '0;
      r_ovr_cnt     <= '0;
      r_tmo_err_cnt <= '0;
    end else begin
      if (w_crc && r_crc_cnt != 16'hFFFF)                    r_crc_cnt     <= r_crc_cnt + 1'b1;
      if ((w_err_len || w_err_k) && r_len_cnt != 16'hFFFF)   r_len_cnt     <= r_len_cnt + 1'b1;
      if (w_ovr && r_ovr_cnt != 16'hFFFF)                    r_ovr_cnt     <= r_ovr_cnt + 1'b1;
      if (w_err_tmo && r_tmo_err_cnt != 16'hFFFF)            r_tmo_err_cnt <= r_tmo_err_cnt + 1'b1;
    end
  end

  assign crc_err_cnt = r_crc_cnt;
  assign len_err_cnt = r_len_cnt;
  assign ovr_cnt     = r_ovr_cnt;
  assign tmo_err_cnt = r_tmo_err_cnt;
`endif

endmodule

// File: tb/tb_shared_data_rx_mc_m.sv
// Bench for shared_data_rx_mc_m: directed/randomized frames against a frame-level reference model.
module tb_shared_data_rx_mc_m;
  localparam int DB  = 4;
  localparam int MW  = 16;
  localparam int CH  = 2;
  localparam int AW  = 16;
  localparam int TMO = 64;
  localparam logic [7:0] KS = 8'h5C;
  localparam logic [7:0] KE = 8'h3C;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_isk, rx_valid;
  logic [CH-1:0]     wr_valid, wr_ready;
  logic [CH*AW-1:0]  wr_addr;
  logic [CH*DB*8-1:0] wr_data;
  logic              busy, frame_ok, frame_err;
`ifdef SHARED_DATA_RX_STATS_EN
  logic [15:0] crc_err_cnt, len_err_cnt, ovr_cnt, tmo_err_cnt;
`endif

  shared_data_rx_mc_m #(.DATA_BYTES(DB), .MAX_WORDS(MW), .CH_COUNT(CH), .ADDR_W(AW),
                        .TIMEOUT_CYC(TMO), .K_START(KS), .K_STOP(KE)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_isk(rx_isk), .rx_valid(rx_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_ok(frame_ok), .frame_err(frame_err)
`ifdef SHARED_DATA_RX_STATS_EN
    , .crc_err_cnt(crc_err_cnt), .len_err_cnt(len_err_cnt), .ovr_cnt(ovr_cnt), .tmo_err_cnt(tmo_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ok_seen = 0, err_seen = 0, ok_exp = 0, err_exp = 0;
  int crc_m = 0, len_m = 0, ovr_m = 0, tmo_m = 0;
  int max_gap = 2;
  logic [47:0] exp_q0[$];
  logic [47:0] exp_q1[$];
  logic [7:0]  pl [80];
  int          pl_len;
  logic [1:0]  ready_mode [CH];  // 0 random, 1 low, 2 high
  logic [CH-1:0] stall_prev;
  logic [47:0] prev_obs [CH];
  logic [47:0] mon_obs, mon_exp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every handshake pops the channel's expected queue; stalls must hold addr/data.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        mon_obs = {wr_addr[c*AW +: AW], wr_data[c*DB*8 +: DB*8]};
        if (wr_valid[c] && stall_prev[c]) check("stall_stable", mon_obs, prev_obs[c]);
        if (wr_valid[c] && wr_ready[c]) begin
          mon_exp = {48{1'bx}};
          if (c == 0 && exp_q0.size() != 0) mon_exp = exp_q0.pop_front();
          if (c == 1 && exp_q1.size() != 0) mon_exp = exp_q1.pop_front();
          check(c == 0 ? "wr_ch0" : "wr_ch1", mon_obs, mon_exp);
        end
        stall_prev[c] = wr_valid[c] && !wr_ready[c];
        prev_obs[c]   = mon_obs;
      end
      ok_seen  += int'(frame_ok);
      err_seen += int'(frame_err);
    end
  end

  initial begin
    wr_ready = '0;
    forever begin
      @(posedge clk); #1;
      for (int c = 0; c < CH; c++)
        case (ready_mode[c])
          2'd0:    wr_ready[c] = 1'($urandom_range(0, 1));
          2'd1:    wr_ready[c] = 1'b0;
          default: wr_ready[c] = 1'b1;
        endcase
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic k);
    int gap;
    gap = $urandom_range(0, max_gap);
    repeat (gap) begin
      rx_valid = 1'b0; rx_data = 8'($urandom); rx_isk = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    rx_valid = 1'b1; rx_data = d; rx_isk = k;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_isk = 1'b0;
  endtask

  // Reference model: frame outcome and the word list each channel must write.
  task automatic send_frame(input logic [7:0] seg, input bit corrupt);
    int sum, cnt;
    logic [15:0] ck;
    logic [31:0] word;
    bit good, exp_ok, busy_m;
    sum = seg;
    for (int i = 0; i < pl_len; i++) sum += pl[i];
    ck = 16'hFFFF - 16'(sum);
    if (corrupt) ck = ck ^ 16'h0001;
    cnt = (pl_len + DB - 1) / DB;
    good = !corrupt && cnt != 0 && seg != 8'hFF;
    send_byte(KS, 1'b1);
    send_byte(seg, 1'b0);
    for (int i = 0; i < pl_len; i++) send_byte(pl[i], 1'b0);
    send_byte(KE, 1'b1);
    send_byte(ck[15:8], 1'b0);
    send_byte(ck[7:0], 1'b0);
    busy_m = exp_q0.size() != 0 || exp_q1.size() != 0;
    exp_ok = good && !busy_m;
    if (!good) crc_m++;
    if (good && busy_m) ovr_m++;
    if (exp_ok) begin
      ok_exp++;
      for (int w = 0; w < cnt; w++) begin
        word = '0;
        for (int b = 0; b < DB; b++)
          if (w * DB + b < pl_len) word[b*8 +: 8] = pl[w*DB + b];
        exp_q0.push_back({16'((int'(seg) * MW * DB) + w * DB), word});
        exp_q1.push_back({16'((int'(seg) * MW * DB) + w * DB), word});
      end
    end else begin
      err_exp++;
    end
    @(posedge clk); #1;
    check("frame_ok", frame_ok, exp_ok);
    check("frame_err", frame_err, !exp_ok);
  endtask

  task automatic wait_drain();
    int i = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && i < 3000) begin
      @(posedge clk); #1; i++;
    end
    check("drain_done", (exp_q0.size() == 0 && exp_q1.size() == 0), 1);
    check("busy_after_drain", busy, 0);
  endtask

  task automatic fill_seq(input int n, input logic [7:0] first);
    pl_len = n;
    for (int i = 0; i < n; i++) pl[i] = first + 8'(i);
  endtask

  task automatic fill_rand(input int n);
    pl_len = n;
    for (int i = 0; i < n; i++) pl[i] = 8'($urandom);
  endtask

  task automatic check_stats();
`ifdef SHARED_DATA_RX_STATS_EN
    check("crc_err_cnt", crc_err_cnt, crc_m);
    check("len_err_cnt", len_err_cnt, len_m);
    check("ovr_cnt", ovr_cnt, ovr_m);
    check("tmo_err_cnt", tmo_err_cnt, tmo_m);
`endif
  endtask

  initial begin
    int e0, i;
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_isk = 1'b0;
    for (int c = 0; c < CH; c++) ready_mode[c] = 2'd2;
    // clock/reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_ok", frame_ok, 0);
    check("rst_frame_err", frame_err, 0);
    check_stats();
    rst = 1'b0;
    @(posedge clk); #1;

    // seg 3, bytes 01..08: C0/04030201 then C4/08070605 on each channel
    fill_seq(8, 8'h01);
    send_frame(8'd3, 1'b0);
    wait_drain();
    // partial last word is zero padded
    fill_seq(5, 8'h11);
    send_frame(8'd3, 1'b0);
    wait_drain();
    // corrupted checksum LSB
    fill_seq(8, 8'h01);
    send_frame(8'd3, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("no_wr_after_crc", wr_valid, 0);
    // empty payload and reserved segment are rejected
    pl_len = 0;
    send_frame(8'd7, 1'b0);
    fill_seq(4, 8'hA0);
    send_frame(8'hFF, 1'b0);
    // randomized frames with random backpressure
    for (int c = 0; c < CH; c++) ready_mode[c] = 2'd0;
    for (int n = 0; n < 8; n++) begin
      fill_rand($urandom_range(0, MW * DB));
      send_frame(8'($urandom), 1'($urandom_range(0, 3) == 0));
      wait_drain();
    end
    // max-length frame is the boundary case that must still be accepted
    fill_rand(MW * DB);
    send_frame(8'h22, 1'b0);
    wait_drain();

    // ch1 stalled: ch0 finishes, ch1 holds; a second good frame is an overrun
    ready_mode[0] = 2'd2; ready_mode[1] = 2'd1;
    fill_seq(8, 8'h31);
    send_frame(8'd5, 1'b0);
    i = 0;
    while (exp_q0.size() != 0 && i < 200) begin @(posedge clk); #1; i++; end
    check("ch0_done_first", exp_q0.size(), 0);
    check("busy_stalled", busy, 1);
    check("ch1_valid_stalled", wr_valid, 2'b10);
    fill_seq(6, 8'h91);
    send_frame(8'd9, 1'b0);
    repeat (50) @(posedge clk);
    #1;
    check("ch1_still_stalled", wr_valid, 2'b10);
    ready_mode[1] = 2'd0;
    wait_drain();

    // timeout after 3 payload bytes, then a good frame
    max_gap = 0;
    e0 = err_seen;
    send_byte(KS, 1'b1); send_byte(8'd4, 1'b0);
    send_byte(8'hC1, 1'b0); send_byte(8'hC2, 1'b0); send_byte(8'hC3, 1'b0);
    repeat (TMO - 4) @(posedge clk);
    #1;
    check("tmo_not_early", err_seen - e0, 0);
    repeat (10) @(posedge clk);
    #1;
    check("tmo_err", err_seen - e0, 1);
    tmo_m++; err_exp++;
    max_gap = 2;
    fill_rand(11);
    send_frame(8'd4, 1'b0);
    wait_drain();

    // a start mid-frame restarts silently
    e0 = err_seen;
    send_byte(KS, 1'b1); send_byte(8'd6, 1'b0); send_byte(8'h55, 1'b0);
    fill_rand(7);
    send_frame(8'd6, 1'b0);
    wait_drain();
    check("restart_no_err", err_seen - e0, 0);

    // unexpected K-character inside payload
    send_byte(KS, 1'b1); send_byte(8'd2, 1'b0); send_byte(8'h10, 1'b0);
    send_byte(8'hBC, 1'b1);
    check("kchar_err", frame_err, 1);
    len_m++; err_exp++;
    // one byte beyond capacity
    send_byte(KS, 1'b1); send_byte(8'd2, 1'b0);
    for (int k = 0; k < MW * DB; k++) send_byte(8'(k), 1'b0);
    check("len_no_early_err", frame_err, 0);
    send_byte(8'hEE, 1'b0);
    check("len_err", frame_err, 1);
    len_m++; err_exp++;
    repeat (3) @(posedge clk);
    #1;
    check_stats();
    check("ok_total", ok_seen, ok_exp);
    check("err_total", err_seen, err_exp);

    // reset mid-drain drops outstanding writes immediately
    ready_mode[0] = 2'd1; ready_mode[1] = 2'd1;
    fill_seq(12, 8'h61);
    send_frame(8'd1, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_wr_valid", wr_valid, 0);
    check("rst_async_busy", busy, 0);
    exp_q0.delete(); exp_q1.delete();
    crc_m = 0; len_m = 0; ovr_m = 0; tmo_m = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    ready_mode[0] = 2'd0; ready_mode[1] = 2'd0;
    repeat (20) @(posedge clk);
    #1;
    check("no_resume_after_rst", wr_valid, 0);
    fill_rand(9);
    send_frame(8'd12, 1'b0);
    wait_drain();
    check_stats();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
